// File: rtl/iwdg_pkg.sv
// Shared definitions for the windowed independent watchdog: key values,
// register map, status bit positions and the bus handshake state type.
package iwdg_pkg;

    // Key register command values
    localparam logic [15:0] KEY_START  = 16'hCCCC;
    localparam logic [15:0] KEY_RELOAD = 16'hAAAA;
    localparam logic [15:0] KEY_UNLOCK = 16'h5555;

    // Register indices (position in the decode vector)
    localparam int NUM_REGS = 6;
    localparam int REG_KR   = 0;
    localparam int REG_PR   = 1;
    localparam int REG_RLR  = 2;
    localparam int REG_SR   = 3;
    localparam int REG_WINR = 4;
    localparam int REG_EWCR = 5;

    // Byte offsets from the block base address
    localparam logic [31:0] OFF_KR   = 32'h00;
    localparam logic [31:0] OFF_PR   = 32'h04;
    localparam logic [31:0] OFF_RLR  = 32'h08;
    localparam logic [31:0] OFF_SR   = 32'h0C;
    localparam logic [31:0] OFF_WINR = 32'h10;
    localparam logic [31:0] OFF_EWCR = 32'h14;

    // Status register bit positions
    localparam int SR_RUN  = 0;
    localparam int SR_UNLK = 1;
    localparam int SR_EWIF = 2;

    // Bus handshake states
    typedef enum logic {
        BUS_IDLE = 1'b0,
        BUS_ACK  = 1'b1
    } bus_state_t;

    // Map a register index to its byte offset; unknown indices map to an
    // address no access can match within the block window.
    function automatic logic [31:0] reg_offset(input int idx);
        logic [31:0] off;
        case (idx)
            REG_KR:   off = OFF_KR;
            REG_PR:   off = OFF_PR;
            REG_RLR:  off = OFF_RLR;
            REG_SR:   off = OFF_SR;
            REG_WINR: off = OFF_WINR;
            REG_EWCR: off = OFF_EWCR;
            default:  off = 32'hFFFF_FFFC;
        endcase
        return off;
    endfunction

endpackage

// File: rtl/iwdg_countdown.sv
// Watchdog timing core: prescaler, down-counter, refresh-window check,
// early-warning compare, reset-request pulse and early-warning flag.
module iwdg_countdown
    import iwdg_pkg::*;
#(
    parameter int CNT_W = 12,
    parameter int PR_W  = 3
) (
    input  logic             clk_m2s,
    input  logic             rst_m2s,
    input  logic             tick_lsi,
    input  logic             start_key,
    input  logic             reload_key,
    input  logic             ewif_clr,
    input  logic [PR_W-1:0]  pr_val,
    input  logic [CNT_W-1:0] rlr_val,
    input  logic [CNT_W-1:0] winr_val,
    input  logic [CNT_W-1:0] ewc_val,
    output logic             running,
    output logic             ewif,
    output logic             ewif_next,
    output logic             rst_iwdg
);

    // Wide enough to hold div-1 for the largest prescaler setting
    localparam int PSC_W = (1 << PR_W) + 1;

    logic             running_reg, running_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [PSC_W-1:0] psc_reg, psc_next;
    logic [PR_W-1:0]  pr_act_reg, pr_act_next;
    logic             ewif_reg;
    logic             rst_reg, rst_next;
    logic             ew_set;
    logic [CNT_W-1:0] cnt_dec;

    // div-1 = 2^(PR+2)-1 is a run of (PR+2) ones; build it bit by bit for the
    // freshly written PR (used at period boundaries) and the latched PR
    // (used for prescaler roll-overs inside the current period).
    logic [PR_W:0]    shift_new, shift_act;
    logic [PSC_W-1:0] div_new_m1, div_act_m1;

    assign shift_new = {1'b0, pr_val}     + (PR_W+1)'(2);
    assign shift_act = {1'b0, pr_act_reg} + (PR_W+1)'(2);

    generate
        for (genvar gi = 0; gi < PSC_W; gi++) begin : g_div
            assign div_new_m1[gi] = ((PR_W+1)'(gi) < shift_new);
            assign div_act_m1[gi] = ((PR_W+1)'(gi) < shift_act);
        end
    endgenerate

    assign cnt_dec = cnt_reg - CNT_W'(1);

    // Next-state: reload key beats the tick, start only acts when stopped,
    // and a window violation plus expiry still yields one pulse.
    always_comb begin
        running_next = running_reg;
        cnt_next     = cnt_reg;
        psc_next     = psc_reg;
        pr_act_next  = pr_act_reg;
        rst_next     = 1'b0;
        ew_set       = 1'b0;

        if (reload_key) begin
            cnt_next    = rlr_val;
            psc_next    = div_new_m1;
            pr_act_next = pr_val;
            if (running_reg && (cnt_reg > winr_val)) begin
                rst_next = 1'b1;
            end
        end else if (start_key && !running_reg) begin
            running_next = 1'b1;
            cnt_next     = rlr_val;
            psc_next     = div_new_m1;
            pr_act_next  = pr_val;
        end else if (running_reg && tick_lsi) begin
            if (psc_reg != '0) begin
                psc_next = psc_reg - PSC_W'(1);
            end else if (cnt_reg == '0) begin
                rst_next    = 1'b1;
                cnt_next    = rlr_val;
                psc_next    = div_new_m1;
                pr_act_next = pr_val;
            end else begin
                psc_next = div_act_m1;
                cnt_next = cnt_dec;
                if (cnt_dec == ewc_val) begin
                    ew_set = 1'b1;
                end
            end
        end
    end

    // Early-warning flag: a set in the same cycle as a clear wins
    always_comb begin
        ewif_next = ewif_reg;
        if (ewif_clr) begin
            ewif_next = 1'b0;
        end
        if (ew_set) begin
            ewif_next = 1'b1;
        end
    end

    // Timing state registers
    always_ff @(posedge clk_m2s or negedge rst_m2s) begin
        if (!rst_m2s) begin
            running_reg <= 1'b0;
            cnt_reg     <= '1;
            psc_reg     <= '0;
            pr_act_reg  <= '0;
            ewif_reg    <= 1'b0;
            rst_reg     <= 1'b0;
        end else begin
            running_reg <= running_next;
            cnt_reg     <= cnt_next;
            psc_reg     <= psc_next;
            pr_act_reg  <= pr_act_next;
            ewif_reg    <= ewif_next;
            rst_reg     <= rst_next;
        end
    end

    assign running  = running_reg;
    assign ewif     = ewif_reg;
    assign rst_iwdg = rst_reg;

endmodule

// File: rtl/iwdg_win.sv
// Windowed independent watchdog: Wishbone slave front end, register file
// and key decode around the iwdg_countdown timing core.
module iwdg_win
    import iwdg_pkg::*;
#(
    parameter int          CNT_W    = 12,
    parameter int          PR_W     = 3,
    parameter int          DAT_W    = 16,
    parameter logic [31:0] BASE_ADR = 32'h0100_0000
) (
    input  logic             clk_m2s,
    input  logic             rst_m2s,
    input  logic             tick_lsi,
    input  logic [DAT_W-1:0] dat_m2s,
    input  logic [31:0]      adr_m2s,
    input  logic             cyc_m2s,
    input  logic             stb_m2s,
    input  logic             we_m2s,
    output logic [DAT_W-1:0] dat_s2m,
    output logic             ack_s2m,
    output logic             rst_iwdg,
    output logic             ewi_irq
);

    bus_state_t       state_reg, state_next;
    logic [31:0]      adr_reg;
    logic [DAT_W-1:0] dat_reg;
    logic             we_reg;

    logic [PR_W-1:0]  pr_reg, pr_next;
    logic [CNT_W-1:0] rlr_reg, rlr_next;
    logic [CNT_W-1:0] winr_reg, winr_next;
    logic [CNT_W:0]   ewcr_reg, ewcr_next;
    logic             unlocked_reg, unlocked_next;
    logic             ewi_irq_reg;

    logic [NUM_REGS-1:0] sel;
    logic [DAT_W-1:0]    rdata;
    logic                wr_en;
    logic                is_start, is_reload, is_unlock;
    logic                key_start, key_reload, key_unlock, key_other;
    logic                ewif_clr;
    logic                running, ewif, ewif_next;

    // Address decode against the captured request address
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_sel
            assign sel[gi] = (adr_reg == (BASE_ADR + reg_offset(gi)));
        end
    endgenerate

    // Writes take effect on the ACK edge of the captured request
    assign wr_en      = (state_reg == BUS_ACK) && we_reg;
    assign is_start   = (dat_reg == DAT_W'(KEY_START));
    assign is_reload  = (dat_reg == DAT_W'(KEY_RELOAD));
    assign is_unlock  = (dat_reg == DAT_W'(KEY_UNLOCK));
    assign key_start  = wr_en && sel[REG_KR] && is_start;
    assign key_reload = wr_en && sel[REG_KR] && is_reload;
    assign key_unlock = wr_en && sel[REG_KR] && is_unlock;
    assign key_other  = wr_en && sel[REG_KR] && !(is_start || is_reload || is_unlock);
    assign ewif_clr   = wr_en && sel[REG_SR] && dat_reg[SR_EWIF];

    // Bus FSM next state and handshake outputs
    always_comb begin
        state_next = state_reg;
        ack_s2m    = 1'b0;
        dat_s2m    = '0;
        case (state_reg)
            BUS_IDLE: begin
                if (cyc_m2s && stb_m2s) begin
                    state_next = BUS_ACK;
                end
            end
            BUS_ACK: begin
                state_next = BUS_IDLE;
                ack_s2m    = 1'b1;
                if (!we_reg) begin
                    dat_s2m = rdata;
                end
            end
            default: state_next = BUS_IDLE;
        endcase
    end

    // Bus state and request capture
    always_ff @(posedge clk_m2s or negedge rst_m2s) begin
        if (!rst_m2s) begin
            state_reg <= BUS_IDLE;
            adr_reg   <= '0;
            dat_reg   <= '0;
            we_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == BUS_IDLE && cyc_m2s && stb_m2s) begin
                adr_reg <= adr_m2s;
                dat_reg <= dat_m2s;
                we_reg  <= we_m2s;
            end
        end
    end

    // Register file updates: protected registers only while unlocked
    always_comb begin
        pr_next       = pr_reg;
        rlr_next      = rlr_reg;
        winr_next     = winr_reg;
        ewcr_next     = ewcr_reg;
        unlocked_next = unlocked_reg;
        if (wr_en && unlocked_reg) begin
            if (sel[REG_PR])   pr_next   = dat_reg[PR_W-1:0];
            if (sel[REG_RLR])  rlr_next  = dat_reg[CNT_W-1:0];
            if (sel[REG_WINR]) winr_next = dat_reg[CNT_W-1:0];
            if (sel[REG_EWCR]) ewcr_next = dat_reg[CNT_W:0];
        end
        if (key_unlock) begin
            unlocked_next = 1'b1;
        end
        if (key_reload || key_other) begin
            unlocked_next = 1'b0;
        end
    end

    // Register file storage; the interrupt tracks next-state flag and enable
    // so it moves in the same cycle as the flag itself
    always_ff @(posedge clk_m2s or negedge rst_m2s) begin
        if (!rst_m2s) begin
            pr_reg       <= '0;
            rlr_reg      <= '1;
            winr_reg     <= '1;
            ewcr_reg     <= '0;
            unlocked_reg <= 1'b0;
            ewi_irq_reg  <= 1'b0;
        end else begin
            pr_reg       <= pr_next;
            rlr_reg      <= rlr_next;
            winr_reg     <= winr_next;
            ewcr_reg     <= ewcr_next;
            unlocked_reg <= unlocked_next;
            ewi_irq_reg  <= ewif_next && ewcr_next[CNT_W];
        end
    end

    // Read data mux; KR and unmapped offsets read as zero
    always_comb begin
        rdata = '0;
        if (sel[REG_PR])   rdata[PR_W-1:0]  = pr_reg;
        if (sel[REG_RLR])  rdata[CNT_W-1:0] = rlr_reg;
        if (sel[REG_WINR]) rdata[CNT_W-1:0] = winr_reg;
        if (sel[REG_EWCR]) rdata[CNT_W:0]   = ewcr_reg;
        if (sel[REG_SR]) begin
            rdata[SR_RUN]  = running;
            rdata[SR_UNLK] = unlocked_reg;
            rdata[SR_EWIF] = ewif;
        end
    end

    assign ewi_irq = ewi_irq_reg;

    iwdg_countdown #(
        .CNT_W (CNT_W),
        .PR_W  (PR_W)
    ) u_countdown (
        .clk_m2s    (clk_m2s),
        .rst_m2s    (rst_m2s),
        .tick_lsi   (tick_lsi),
        .start_key  (key_start),
        .reload_key (key_reload),
        .ewif_clr   (ewif_clr),
        .pr_val     (pr_reg),
        .rlr_val    (rlr_reg),
        .winr_val   (winr_reg),
        .ewc_val    (ewcr_reg[CNT_W-1:0]),
        .running    (running),
        .ewif       (ewif),
        .ewif_next  (ewif_next),
        .rst_iwdg   (rst_iwdg)
    );

endmodule

// File: tb/tb_iwdg_win.sv
// Scoreboard bench for iwdg_win: stimulus queues expected bus responses,
// reset-request pulses and interrupt edges; a negedge monitor checks them.
module tb_iwdg_win;

    localparam logic [31:0] BASE   = 32'h0100_0000;
    localparam logic [31:0] A_KR   = BASE + 32'h00;
    localparam logic [31:0] A_PR   = BASE + 32'h04;
    localparam logic [31:0] A_RLR  = BASE + 32'h08;
    localparam logic [31:0] A_SR   = BASE + 32'h0C;
    localparam logic [31:0] A_WINR = BASE + 32'h10;
    localparam logic [31:0] A_EWCR = BASE + 32'h14;
    localparam logic [31:0] A_UNM  = BASE + 32'h18;

    logic        clk_m2s = 1'b0;
    logic        rst_m2s = 1'b0;
    logic        tick_lsi = 1'b0;
    logic [15:0] dat_m2s = '0;
    logic [31:0] adr_m2s = '0;
    logic        cyc_m2s = 1'b0;
    logic        stb_m2s = 1'b0;
    logic        we_m2s  = 1'b0;
    logic [15:0] dat_s2m;
    logic        ack_s2m;
    logic        rst_iwdg;
    logic        ewi_irq;

    iwdg_win #(
        .CNT_W    (12),
        .PR_W     (3),
        .DAT_W    (16),
        .BASE_ADR (BASE)
    ) dut (
        .clk_m2s  (clk_m2s),
        .rst_m2s  (rst_m2s),
        .tick_lsi (tick_lsi),
        .dat_m2s  (dat_m2s),
        .adr_m2s  (adr_m2s),
        .cyc_m2s  (cyc_m2s),
        .stb_m2s  (stb_m2s),
        .we_m2s   (we_m2s),
        .dat_s2m  (dat_s2m),
        .ack_s2m  (ack_s2m),
        .rst_iwdg (rst_iwdg),
        .ewi_irq  (ewi_irq)
    );

    always #5 clk_m2s = ~clk_m2s;

    int cycle = 0;
    always @(posedge clk_m2s) cycle++;

    typedef struct {
        int    cyc;
        int    val;
        string name;
    } exp_t;

    exp_t bus_q[$];
    exp_t ewi_q[$];
    int   rst_q[$];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input longint act, input longint expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cycle);
        end
    endtask

    // Monitor: one line per observed transaction, compared against queues
    logic ewi_prev = 1'b0;
    always @(negedge clk_m2s) begin
        exp_t e;
        int   c;
        if (rst_m2s) begin
            if (ack_s2m) begin
                if (bus_q.size() == 0) begin
                    chk("bus_unexpected_ack", 1, 0);
                end else begin
                    e = bus_q.pop_front();
                    $display("bus  %-16s cycle=%0d dat=0x%04h", e.name, cycle, dat_s2m);
                    chk({e.name, "_ack_cycle"}, cycle, e.cyc);
                    chk({e.name, "_dat"}, dat_s2m, e.val);
                end
            end
            if (rst_iwdg) begin
                $display("rst_iwdg pulse cycle=%0d", cycle);
                if (rst_q.size() == 0) begin
                    chk("rst_iwdg_unexpected", 1, 0);
                end else begin
                    c = rst_q.pop_front();
                    chk("rst_iwdg_cycle", cycle, c);
                end
            end
            if (ewi_irq !== ewi_prev) begin
                $display("ewi_irq -> %0b cycle=%0d", ewi_irq, cycle);
                if (ewi_q.size() == 0) begin
                    chk("ewi_unexpected_edge", 1, 0);
                end else begin
                    e = ewi_q.pop_front();
                    chk({e.name, "_cycle"}, cycle, e.cyc);
                    chk({e.name, "_val"}, ewi_irq, e.val);
                end
            end
        end
        ewi_prev = ewi_irq;
    end

    task automatic push_bus(input int c, input int v, input string nm);
        exp_t e;
        e.cyc = c; e.val = v; e.name = nm;
        bus_q.push_back(e);
    endtask

    task automatic push_ewi(input int c, input int v, input string nm);
        exp_t e;
        e.cyc = c; e.val = v; e.name = nm;
        ewi_q.push_back(e);
    endtask

    // All bus tasks start and end one time unit after a rising edge
    task automatic wb_write(input logic [31:0] a, input logic [15:0] d,
                            input string nm, input bit tick_on_ack = 1'b0);
        push_bus(cycle + 1, 0, nm);
        adr_m2s = a; dat_m2s = d; we_m2s = 1'b1; cyc_m2s = 1'b1; stb_m2s = 1'b1;
        @(posedge clk_m2s); #1;
        cyc_m2s = 1'b0; stb_m2s = 1'b0; we_m2s = 1'b0;
        tick_lsi = tick_on_ack;
        @(posedge clk_m2s); #1;
        tick_lsi = 1'b0;
    endtask

    task automatic wb_read(input logic [31:0] a, input int expv, input string nm);
        push_bus(cycle + 1, expv, nm);
        adr_m2s = a; we_m2s = 1'b0; cyc_m2s = 1'b1; stb_m2s = 1'b1;
        @(posedge clk_m2s); #1;
        cyc_m2s = 1'b0; stb_m2s = 1'b0;
        @(posedge clk_m2s); #1;
    endtask

    task automatic run_ticks(input int n);
        tick_lsi = 1'b1;
        repeat (n) @(posedge clk_m2s);
        #1;
        tick_lsi = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk_m2s);
        #1;
        chk("reset_ack", ack_s2m, 0);
        chk("reset_dat", dat_s2m, 0);
        chk("reset_rst_iwdg", rst_iwdg, 0);
        chk("reset_ewi", ewi_irq, 0);
        rst_m2s = 1'b1;
        @(posedge clk_m2s); #1;

        wb_read(A_SR,   16'h0000, "sr_reset");
        wb_read(A_PR,   16'h0000, "pr_reset");
        wb_read(A_RLR,  16'h0FFF, "rlr_reset");
        wb_read(A_WINR, 16'h0FFF, "winr_reset");
        wb_read(A_EWCR, 16'h0000, "ewcr_reset");
        wb_read(A_KR,   16'h0000, "kr_read");

        // Locked writes are acked and dropped
        wb_write(A_PR,  16'h0002, "pr_locked_wr");
        wb_write(A_RLR, 16'h0005, "rlr_locked_wr");
        wb_read(A_PR,   16'h0000, "pr_locked_rd");
        wb_read(A_RLR,  16'h0FFF, "rlr_locked_rd");

        // PR=0, RLR=3, start: pulse every 16 ticks
        wb_write(A_KR,  16'h5555, "kr_unlock1");
        wb_write(A_RLR, 16'h0003, "rlr_wr3");
        wb_read(A_SR,   16'h0002, "sr_unlocked");
        wb_write(A_KR,  16'hCCCC, "kr_start");
        wb_read(A_SR,   16'h0003, "sr_running");
        rst_q.push_back(cycle + 16);
        rst_q.push_back(cycle + 32);
        run_ticks(33);

        // PR=2, RLR=5, reload, start again (no effect): 96 ticks
        wb_write(A_KR,  16'h5555, "kr_unlock2");
        wb_write(A_PR,  16'h0002, "pr_wr2");
        wb_write(A_RLR, 16'h0005, "rlr_wr5");
        wb_write(A_KR,  16'hAAAA, "kr_reload1");
        wb_write(A_KR,  16'hCCCC, "kr_start2");
        wb_read(A_PR,   16'h0002, "pr_rd2");
        wb_read(A_RLR,  16'h0005, "rlr_rd5");
        rst_q.push_back(cycle + 96);
        run_ticks(97);

        // Window: WINR=10, RLR=20; reload at cnt=15 violates, at cnt=8 is fine
        wb_write(A_KR,   16'h5555, "kr_unlock3");
        wb_write(A_PR,   16'h0000, "pr_wr0");
        wb_write(A_RLR,  16'h0014, "rlr_wr20");
        wb_write(A_WINR, 16'h000A, "winr_wr10");
        wb_write(A_KR,   16'hAAAA, "kr_reload2");
        run_ticks(20);
        rst_q.push_back(cycle + 2);
        wb_write(A_KR,   16'hAAAA, "kr_reload_viol");
        run_ticks(48);
        wb_write(A_KR,   16'hAAAA, "kr_reload_ok");
        rst_q.push_back(cycle + 84);
        run_ticks(85);

        // Early warning: EWCR = EWIE | 4, RLR=10
        wb_write(A_SR,   16'h0004, "sr_w1c_stale");
        wb_write(A_KR,   16'h5555, "kr_unlock4");
        wb_write(A_RLR,  16'h000A, "rlr_wr10");
        wb_write(A_WINR, 16'h0FFF, "winr_wr_off");
        wb_write(A_EWCR, 16'h1004, "ewcr_wr");
        wb_read(A_EWCR,  16'h1004, "ewcr_rd");
        wb_write(A_KR,   16'hAAAA, "kr_reload3");
        push_ewi(cycle + 24, 1, "ewi_rise");
        run_ticks(26);
        wb_read(A_SR,    16'h0005, "sr_ewif_set");
        push_ewi(cycle + 2, 0, "ewi_fall");
        wb_write(A_SR,   16'h0004, "sr_w1c");
        wb_read(A_SR,    16'h0001, "sr_ewif_clr");

        // Reload key on the terminal tick: reload wins, no pulse
        wb_write(A_KR,   16'h5555, "kr_unlock5");
        wb_write(A_EWCR, 16'h0000, "ewcr_wr0");
        wb_write(A_KR,   16'hAAAA, "kr_reload4");
        run_ticks(43);
        wb_write(A_KR,   16'hAAAA, "kr_reload_term", 1'b1);
        rst_q.push_back(cycle + 44);
        run_ticks(45);

        // Unmapped offset
        wb_read(A_UNM,   16'h0000, "unmapped_rd");

        // Async reset during the ACK of a write
        wb_write(A_KR,   16'h5555, "kr_unlock6");
        adr_m2s = A_PR; dat_m2s = 16'h0005; we_m2s = 1'b1; cyc_m2s = 1'b1; stb_m2s = 1'b1;
        @(posedge clk_m2s); #1;
        cyc_m2s = 1'b0; stb_m2s = 1'b0; we_m2s = 1'b0;
        chk("ack_before_reset", ack_s2m, 1);
        #1 rst_m2s = 1'b0;
        #1;
        chk("ack_async_drop", ack_s2m, 0);
        chk("rst_dat", dat_s2m, 0);
        chk("rst_rst_iwdg", rst_iwdg, 0);
        chk("rst_ewi", ewi_irq, 0);
        repeat (2) @(posedge clk_m2s);
        #1 rst_m2s = 1'b1;
        wb_read(A_PR,    16'h0000, "pr_after_rst");
        wb_read(A_RLR,   16'h0FFF, "rlr_after_rst");
        wb_read(A_WINR,  16'h0FFF, "winr_after_rst");
        wb_read(A_EWCR,  16'h0000, "ewcr_after_rst");
        wb_read(A_SR,    16'h0000, "sr_after_rst");
        run_ticks(20);

        repeat (4) @(posedge clk_m2s);
        #1;
        chk("bus_q_drained", bus_q.size(), 0);
        chk("rst_q_drained", rst_q.size(), 0);
        chk("ewi_q_drained", ewi_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
